// File: rtl/gain_seq_pkg.sv
// Shared constants, state encoding and saturation-bound helpers for the gain sequencer.
package gain_seq_pkg;

    localparam int DEF_P      = 4;
    localparam int DEF_F      = 13;
    localparam int DEF_WIDTH  = 1 + DEF_P + DEF_F;
    localparam int DEF_NBANDS = 5;
    localparam int UNITY_GAIN = 1 << DEF_F;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gs_state_e;

    // Largest positive value representable in a signed word of width w.
    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a signed word of width w.
    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/gain_seq_reduce.sv
// Narrows the band accumulator to one output word.
// GAIN_SEQ_SAT_EN defined: clamp to the signed output range; undefined: keep the low bits.
module gain_seq_reduce
    import gain_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACCW  = DEF_WIDTH + 3
) (
    input  logic signed [ACCW-1:0]  i_acc,
    output logic        [WIDTH-1:0] o_y
);

`ifdef GAIN_SEQ_SAT_EN
    localparam logic signed [ACCW-1:0] ACC_MAX = ACCW'(sat_max(WIDTH));
    localparam logic signed [ACCW-1:0] ACC_MIN = ACCW'(sat_min(WIDTH));

    // Clamp the accumulator into the output range.
    always_comb begin
        o_y = i_acc[WIDTH-1:0];
        if (i_acc > ACC_MAX) begin
            o_y = ACC_MAX[WIDTH-1:0];
        end else if (i_acc < ACC_MIN) begin
            o_y = ACC_MIN[WIDTH-1:0];
        end else begin
            o_y = i_acc[WIDTH-1:0];
        end
    end
`else
    logic [ACCW-WIDTH-1:0] w_unused_hi;

    // Two's-complement wrap: the high accumulator bits are simply dropped.
    always_comb begin
        o_y         = i_acc[WIDTH-1:0];
        w_unused_hi = i_acc[ACCW-1:WIDTH];
    end
`endif

endmodule

// File: rtl/gain_sequencer.sv
// Sequences NBANDS band samples through one shared external Gain multiplier and sums them.
// Build option GAIN_SEQ_SAT_EN selects saturating rather than wrapping output reduction.
module gain_sequencer
    import gain_seq_pkg::*;
#(
    parameter int P      = DEF_P,
    parameter int F      = DEF_F,
    parameter int WIDTH  = 1 + P + F,
    parameter int NBANDS = DEF_NBANDS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_valid,
    input  logic [NBANDS*WIDTH-1:0]   bands_in,
    input  logic                      gain_we,
    input  logic [3:0]                gain_addr,
    input  logic [WIDTH-1:0]          gain_wdata,
    output logic [WIDTH-1:0]          mult_a,
    output logic [WIDTH-1:0]          mult_b,
    input  logic [WIDTH-1:0]          mult_y,
    output logic [WIDTH-1:0]          y_out,
    output logic                      y_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int                IDXW  = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    localparam int                ACCW  = WIDTH + $clog2(NBANDS);
    localparam logic [IDXW-1:0]   LAST  = IDXW'(NBANDS - 1);
    localparam logic [4:0]        NB5   = 5'(NBANDS);
    localparam logic [WIDTH-1:0]  UNITY = WIDTH'(longint'(1) << F);

    gs_state_e              r_state;
    gs_state_e              w_state_nxt;
    logic [IDXW-1:0]        r_idx;
    logic signed [ACCW-1:0] r_acc;
    logic [WIDTH-1:0]       r_sample [NBANDS];
    logic [WIDTH-1:0]       r_gain   [NBANDS];
    logic [WIDTH-1:0]       r_y_out;
    logic                   r_y_valid;
    logic                   r_overrun;
    logic                   w_last;
    logic                   w_addr_ok;
    logic signed [ACCW-1:0] w_acc_sum;
    logic [WIDTH-1:0]       w_reduced;

    assign w_last    = (r_idx == LAST);
    assign w_addr_ok = ({1'b0, gain_addr} < NB5);
    assign w_acc_sum = r_acc + {{(ACCW-WIDTH){mult_y[WIDTH-1]}}, mult_y};

    gain_seq_reduce #(
        .WIDTH (WIDTH),
        .ACCW  (ACCW)
    ) u_reduce (
        .i_acc (w_acc_sum),
        .o_y   (w_reduced)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: one RUN cycle per band, back to IDLE after the last band.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (sample_valid) w_state_nxt = RUN;
                else              w_state_nxt = IDLE;
            end
            RUN: begin
                if (w_last) w_state_nxt = IDLE;
                else        w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Multiplier operands are driven only while a band is being processed.
    always_comb begin
        mult_a = '0;
        mult_b = '0;
        if (r_state == RUN) begin
            mult_a = r_sample[r_idx];
            mult_b = r_gain[r_idx];
        end else begin
            mult_a = '0;
            mult_b = '0;
        end
    end

    // Sample capture, band index, accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_acc     <= '0;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
            for (int k = 0; k < NBANDS; k++) r_sample[k] <= '0;
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        for (int k = 0; k < NBANDS; k++) r_sample[k] <= bands_in[k*WIDTH +: WIDTH];
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_sum;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_y_out   <= w_reduced;
                        r_y_valid <= 1'b1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Gain file: a write lands on the edge, so the band in flight this cycle still sees the old gain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBANDS; k++) r_gain[k] <= UNITY;
        end else if (gain_we && w_addr_ok) begin
            r_gain[gain_addr[IDXW-1:0]] <= gain_wdata;
        end
    end

    // Sticky flag for samples that arrive while a computation is still in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (sample_valid && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign y_out   = r_y_out;
    assign y_valid = r_y_valid;
    assign busy    = (r_state != IDLE);
    assign overrun = r_overrun;

endmodule

// File: tb/tb_gain_sequencer.sv
// Self-checking bench for gain_sequencer with an external Gain model and an arithmetic reference.
module tb_gain_sequencer;

    localparam int P      = 4;
    localparam int F      = 13;
    localparam int WIDTH  = 18;
    localparam int NBANDS = 5;
    localparam int BW     = NBANDS * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_valid = 1'b0;
    logic [BW-1:0]    bands_in = '0;
    logic             gain_we = 1'b0;
    logic [3:0]       gain_addr = 4'd0;
    logic [WIDTH-1:0] gain_wdata = '0;
    logic [WIDTH-1:0] mult_a, mult_b, mult_y, y_out;
    logic             y_valid, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int model_gain [NBANDS];

    gain_sequencer #(.P(P), .F(F), .WIDTH(WIDTH), .NBANDS(NBANDS)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .bands_in(bands_in),
        .gain_we(gain_we), .gain_addr(gain_addr), .gain_wdata(gain_wdata),
        .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y),
        .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // External Gain block: Q4.13 product, arithmetic shift back by F, low WIDTH bits.
    always_comb begin
        logic signed [2*WIDTH-1:0] prod;
        prod   = $signed(mult_a) * $signed(mult_b);
        mult_y = WIDTH'(prod >>> F);
    end

    function automatic logic [WIDTH-1:0] ref_eq(input logic [BW-1:0] b, input int g [NBANDS]);
        longint acc = 0;
        longint p, t;
        int s;
        for (int k = 0; k < NBANDS; k++) begin
            s = $signed(b[k*WIDTH +: WIDTH]);
            p = (longint'(s) * longint'(g[k])) >>> F;
            t = p & ((longint'(1) << WIDTH) - 1);
            if (t >= (longint'(1) << (WIDTH - 1))) t = t - (longint'(1) << WIDTH);
            acc = acc + t;
        end
`ifdef GAIN_SEQ_SAT_EN
        if (acc > (longint'(1) << (WIDTH - 1)) - 1) acc = (longint'(1) << (WIDTH - 1)) - 1;
        if (acc < -(longint'(1) << (WIDTH - 1)))    acc = -(longint'(1) << (WIDTH - 1));
`endif
        return WIDTH'(acc);
    endfunction

    function automatic logic [BW-1:0] rand_bands();
        logic [BW-1:0] b;
        for (int k = 0; k < NBANDS; k++) b[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return b;
    endfunction

    function automatic logic [BW-1:0] fill_bands(input logic [WIDTH-1:0] v);
        logic [BW-1:0] b;
        for (int k = 0; k < NBANDS; k++) b[k*WIDTH +: WIDTH] = v;
        return b;
    endfunction

    task automatic model_reset_gains();
        for (int k = 0; k < NBANDS; k++) model_gain[k] = 1 << F;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        sample_valid = 1'b0;
        gain_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset_gains();
    endtask

    task automatic write_gain(input logic [3:0] addr, input logic [WIDTH-1:0] data);
        @(posedge clk);
        #1 gain_we = 1'b1;
        gain_addr = addr;
        gain_wdata = data;
        @(posedge clk);
        #1 gain_we = 1'b0;
        if (addr < NBANDS) model_gain[addr] = $signed(data);
    endtask

    // Issues one sample and observes a bounded window for the result pulse.
    task automatic run_sample(input logic [BW-1:0] b, output logic [WIDTH-1:0] y,
                              output int lat, output int cnt, output bit bok);
        y = '0; lat = -1; cnt = 0; bok = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b1;
        bands_in = b;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        if (busy !== 1'b1) bok = 1'b0;
        for (int i = 1; i <= NBANDS + 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((i < NBANDS) && (busy !== 1'b1)) bok = 1'b0;
            if ((i >= NBANDS) && (busy !== 1'b0)) bok = 1'b0;
            if (y_valid === 1'b1) begin
                cnt++;
                if (cnt == 1) begin lat = i; y = y_out; end
            end
        end
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] y; int lat, cnt; bit bok;
        run_sample(fill_bands(18'h00400), y, lat, cnt, bok);
        write_gain(4'd0, 18'h04000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (y_out !== 18'h0)   begin n_fail++; $display("FAIL reset_y_out got=%h exp=0", y_out); end
        n_checks++; if (y_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (overrun !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        n_checks++; if ((mult_a !== 18'h0) || (mult_b !== 18'h0)) begin
            n_fail++; $display("FAIL reset_mult got a=%h b=%h exp 0/0", mult_a, mult_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset_gains();
        run_sample(fill_bands(18'h00400), y, lat, cnt, bok);
        n_checks++; if (y !== 18'h01400) begin n_fail++; $display("FAIL unity_sum got=%h exp=01400", y); end
        n_checks++; if (lat != NBANDS)   begin n_fail++; $display("FAIL unity_latency got=%0d exp=%0d", lat, NBANDS); end
        n_checks++; if (cnt != 1)        begin n_fail++; $display("FAIL unity_pulses got=%0d exp=1", cnt); end
        n_checks++; if (bok !== 1'b1)    begin n_fail++; $display("FAIL unity_busy_window got=%b exp=1", bok); end
    endtask

    task automatic test_gain_write();
        logic [WIDTH-1:0] y; int lat, cnt; bit bok;
        logic [BW-1:0] b;
        write_gain(4'd2, 18'h04000);
        b = '0;
        b[2*WIDTH +: WIDTH] = 18'h01000;
        run_sample(b, y, lat, cnt, bok);
        n_checks++; if (y !== 18'h02000) begin n_fail++; $display("FAIL gain2_write got=%h exp=02000", y); end
        write_gain(4'd7, 18'h12345);
        run_sample(fill_bands(18'h01000), y, lat, cnt, bok);
        n_checks++; if (y !== 18'h06000) begin n_fail++; $display("FAIL bad_addr_ignored got=%h exp=06000", y); end
    endtask

    task automatic test_negative();
        logic [WIDTH-1:0] y; int lat, cnt; bit bok;
        logic [BW-1:0] b;
        apply_reset();
        b = '0;
        b[0*WIDTH +: WIDTH] = 18'h3E000;
        b[1*WIDTH +: WIDTH] = 18'h02000;
        b[2*WIDTH +: WIDTH] = 18'h02000;
        run_sample(b, y, lat, cnt, bok);
        n_checks++; if (y !== 18'h02000) begin n_fail++; $display("FAIL negative_mix got=%h exp=02000", y); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] y, exp_y; int lat, cnt; bit bok;
`ifdef GAIN_SEQ_SAT_EN
        exp_y = 18'h1FFFF;
`else
        exp_y = 18'h1FFFB;
`endif
        run_sample(fill_bands(18'h1FFFF), y, lat, cnt, bok);
        n_checks++; if (y !== exp_y) begin n_fail++; $display("FAIL overflow got=%h exp=%h", y, exp_y); end
    endtask

    task automatic test_write_during_run();
        logic [WIDTH-1:0] y, y2, exp_y, g2, g4; int lat, cnt; bit bok;
        logic [BW-1:0] b;
        int g_mix [NBANDS];
        b = rand_bands();
        g2 = WIDTH'($urandom_range(0, 32'h7FFF));
        g4 = WIDTH'($urandom_range(0, 32'h7FFF));
        for (int k = 0; k < NBANDS; k++) g_mix[k] = model_gain[k];
        g_mix[4] = $signed(g4);
        exp_y = ref_eq(b, g_mix);
        @(posedge clk);
        #1 sample_valid = 1'b1; bands_in = b;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 gain_we = 1'b1; gain_addr = 4'd2; gain_wdata = g2;
        @(posedge clk);
        #1 gain_addr = 4'd4; gain_wdata = g4;
        @(posedge clk);
        #1 gain_we = 1'b0;
        cnt = 0; lat = -1; y = '0;
        for (int i = 5; i <= NBANDS + 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (y_valid === 1'b1) begin cnt++; if (cnt == 1) begin lat = i; y = y_out; end end
        end
        n_checks++; if (y !== exp_y) begin n_fail++; $display("FAIL write_during_run got=%h exp=%h", y, exp_y); end
        n_checks++; if (lat != NBANDS) begin n_fail++; $display("FAIL write_during_run_lat got=%0d exp=%0d", lat, NBANDS); end
        model_gain[2] = $signed(g2);
        model_gain[4] = $signed(g4);
        b = rand_bands();
        run_sample(b, y2, lat, cnt, bok);
        n_checks++; if (y2 !== ref_eq(b, model_gain)) begin
            n_fail++; $display("FAIL write_visible_next got=%h exp=%h", y2, ref_eq(b, model_gain));
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] y; int lat, cnt; bit bok;
        logic [BW-1:0] b;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1) write_gain(4'($urandom_range(0, 9)), WIDTH'($urandom));
            b = rand_bands();
            run_sample(b, y, lat, cnt, bok);
            n_checks++; if ((y !== ref_eq(b, model_gain)) || (cnt != 1) || (lat != NBANDS)) begin
                n_fail++;
                $display("FAIL random_%0d got=%h lat=%0d cnt=%0d exp=%h lat=%0d cnt=1", n, y, lat, cnt,
                         ref_eq(b, model_gain), NBANDS);
            end
        end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL random_no_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun();
        logic [WIDTH-1:0] y, exp_y; int lat, cnt; bit bok;
        logic [BW-1:0] b1, b3;
        b1 = rand_bands();
        exp_y = ref_eq(b1, model_gain);
        @(posedge clk);
        #1 sample_valid = 1'b1; bands_in = b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(posedge clk);
        #1 sample_valid = 1'b1; bands_in = rand_bands();
        @(posedge clk);
        #1 sample_valid = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        cnt = 0; lat = -1; y = '0;
        for (int i = 3; i <= NBANDS + 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (y_valid === 1'b1) begin cnt++; if (cnt == 1) begin lat = i; y = y_out; end end
        end
        n_checks++; if (y !== exp_y) begin n_fail++; $display("FAIL overrun_first_result got=%h exp=%h", y, exp_y); end
        n_checks++; if (cnt != 1)    begin n_fail++; $display("FAIL overrun_pulses got=%0d exp=1", cnt); end
        n_checks++; if (lat != NBANDS) begin n_fail++; $display("FAIL overrun_latency got=%0d exp=%0d", lat, NBANDS); end
        b3 = rand_bands();
        run_sample(b3, y, lat, cnt, bok);
        n_checks++; if (y !== ref_eq(b3, model_gain)) begin
            n_fail++; $display("FAIL after_overrun got=%h exp=%h", y, ref_eq(b3, model_gain));
        end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_overrun_last();
        logic [WIDTH-1:0] y, exp_y; int lat, cnt;
        logic [BW-1:0] b1;
        apply_reset();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_cleared got=%b exp=0", overrun); end
        b1 = rand_bands();
        exp_y = ref_eq(b1, model_gain);
        @(posedge clk);
        #1 sample_valid = 1'b1; bands_in = b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        for (int i = 1; i < NBANDS; i++) @(posedge clk);
        #1 sample_valid = 1'b1; bands_in = rand_bands();
        @(posedge clk);
        #1 sample_valid = 1'b0;
        cnt = 0; lat = -1; y = '0;
        if (y_valid === 1'b1) begin cnt = 1; lat = NBANDS; y = y_out; end
        for (int i = NBANDS + 1; i <= 2 * NBANDS + 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (y_valid === 1'b1) begin cnt++; if (cnt == 1) begin lat = i; y = y_out; end end
        end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_last_cycle got=%b exp=1", overrun); end
        n_checks++; if ((cnt != 1) || (y !== exp_y)) begin
            n_fail++; $display("FAIL overrun_last_result got=%h cnt=%0d exp=%h cnt=1", y, cnt, exp_y);
        end
    endtask

    task automatic test_abort();
        logic [WIDTH-1:0] y; int lat, cnt; bit bok;
        write_gain(4'd0, 18'h04000);
        @(posedge clk);
        #1 sample_valid = 1'b1; bands_in = fill_bands(18'h00400);
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if ((busy !== 1'b1) || (mult_a !== 18'h00400)) begin
            n_fail++; $display("FAIL abort_in_run got busy=%b a=%h exp busy=1 a=00400", busy, mult_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ((busy !== 1'b0) || (mult_a !== 18'h0) || (mult_b !== 18'h0)) begin
            n_fail++; $display("FAIL abort_immediate got busy=%b a=%h b=%h exp 0/0/0", busy, mult_a, mult_b);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset_gains();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (y_valid === 1'b1) cnt++;
        end
        n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL abort_no_y_valid got=%0d exp=0", cnt); end
        run_sample(fill_bands(18'h00400), y, lat, cnt, bok);
        n_checks++; if ((y !== 18'h01400) || (lat != NBANDS) || (cnt != 1)) begin
            n_fail++; $display("FAIL abort_recover got=%h lat=%0d cnt=%0d exp=01400 lat=%0d cnt=1", y, lat, cnt, NBANDS);
        end
    endtask

    initial begin
        model_reset_gains();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_gain_write();
        test_negative();
        test_overflow();
        test_write_during_run();
        test_random();
        test_overrun();
        test_overrun_last();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gain_sequencer.md
Name: gain_sequencer

Overview:
Time-multiplexes one shared Gain multiplier across NBANDS equalizer band outputs. The per-band gains live in a writable register file.
On each audio sample strobe it latches all band samples, then issues one band per clock to the external Gain instance. It accumulates the weighted bands and emits one summed equalizer output.
Sits between the band filter bank and the output DAC interface.

Parameters:
P, 4, integer bits of signed fixed-point format
F, 13, fractional bits
WIDTH, 1+P+F, sample/gain word width (18 by default)
NBANDS, 5, number of bands sequenced through the multiplier (2..16)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe; bands_in valid this cycle
bands_in  in  NBANDS*WIDTH  band samples; band k at bits [k*WIDTH +: WIDTH]
gain_we  in  1  gain register write enable
gain_addr  in  4  band index to write
gain_wdata  in  WIDTH  new gain, signed Q(P).(F)
mult_a  out  WIDTH  to Gain yk
mult_b  out  WIDTH  to Gain gain_set
mult_y  in  WIDTH  from Gain ykgain (combinational)
y_out  out  WIDTH  summed equalizer output
y_valid  out  1  one-cycle pulse, y_out updated
busy  out  1  high while state != IDLE
overrun  out  1  sticky: a sample_valid arrived while busy

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, acc=0
  - y_out=0, y_valid=0, overrun=0
  - all gains = unity (1<<F, 0x02000)
  - mult_a=mult_b=0
- FSM states: IDLE, RUN.
- IDLE, on sample_valid:
  - latch bands_in into sample regs
  - idx=0, acc=0
  - go to RUN
- RUN, each cycle:
  - mult_a=sample[idx], mult_b=gain[idx], both combinational from registers
  - acc += sign-extended mult_y
  - idx++
- Last RUN cycle (idx==NBANDS-1):
  - y_out <= reduce(acc + mult_y)
  - y_valid <= 1 for one cycle
  - go to IDLE
- Latency: sample_valid sampled at edge E0; y_valid is high in the cycle after edge E(NBANDS). That is NBANDS clocks; 5 by default.
- busy is high from E0 until E(NBANDS).
- Outside RUN, mult_a=mult_b=0.
- Accumulator width: WIDTH+clog2(NBANDS) bits, signed.
- sample_valid while busy (including the last RUN cycle): sample dropped, overrun set to 1; it stays 1 until reset. The current computation is unaffected.
- Gain writes:
  - Accepted in any state when gain_we=1 and gain_addr<NBANDS; gain_addr>=NBANDS is ignored.
  - The new value is visible from the next cycle.
  - A write to the band being multiplied in the same cycle: the old value is used.
- Reset mid-RUN: computation aborted, no y_valid, gains return to unity.

Optional Feature:
GAIN_SEQ_SAT_EN:
- Defined: reduce() saturates acc to [-2^(WIDTH-1), 2^(WIDTH-1)-1], i.e. 0x20000..0x1FFFF.
- Undefined: reduce() keeps the low WIDTH bits (two's-complement wrap).

Decomposition:
- Package gain_seq_pkg holds:
  - default P/F/WIDTH constants
  - UNITY_GAIN = 1<<F
  - state enum {IDLE, RUN}
  - saturation bounds
- Optional sub-module gain_seq_reduce (acc -> WIDTH, sat or wrap per macro).
- The Gain instance stays external, so it can be shared.

Test Plan:
- Reset:
  - stimulus: assert rst_n=0 asynchronously mid-cycle.
  - required: y_out=0, y_valid=0, busy=0, overrun=0; a unity sequence with bands all 0x00400 yields y_out=0x01400 (0.625), y_valid exactly 5 clocks after sample_valid.
- Gain write:
  - stimulus: gain[2]=0x04000 (2.0); sample with band2=0x01000, other bands 0.
  - required: y_out=0x02000.
  - stimulus: gain_addr=7 write.
  - required: no effect on any gain.
- Negative mix:
  - stimulus: bands {0x3E000 (-1.0), 0x02000, 0x02000, 0, 0} at unity.
  - required: y_out=0x02000.
- Overflow:
  - stimulus: all bands 0x1FFFF at unity.
  - required: y_out=0x1FFFF with GAIN_SEQ_SAT_EN; 0x1FFFB without.
- Overrun:
  - stimulus: second sample_valid 2 cycles after the first.
  - required: overrun=1 and sticky; first result unchanged; exactly one y_valid.
- Abort:
  - stimulus: rst_n low during RUN idx 3.
  - required: busy=0 immediately, no y_valid, gains back to 0x02000; a new sample after release is processed normally.
